// File: rtl/gshare_predictor.sv
// gshare_predictor: global-history XOR PC indexed 2-bit counter predictor.
// Predicts each accepted branch, trains with the resolved outcome and keeps
// saturating branch / misprediction statistics.
module gshare_predictor #(
    parameter int unsigned HIST_BITS = 8,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 branch_valid_i,
    input  logic [63:0]          branch_address,
    input  logic                 real_ton,
    output logic                 prediction_o,
    output logic                 pred_valid_o,
    output logic                 mispredict_o,
    output logic [HIST_BITS-1:0] ghr_o,
    output logic [CNT_W-1:0]     branch_count_o,
    output logic [CNT_W-1:0]     mispredict_count_o
);

    localparam int unsigned PHT_N = 1 << HIST_BITS;

    logic [1:0]           r_pht [PHT_N];
    logic [HIST_BITS-1:0] r_ghr;
    logic                 r_pred;
    logic                 r_pred_valid;
    logic                 r_mispredict;
    logic [CNT_W-1:0]     r_branch_cnt;
    logic [CNT_W-1:0]     r_mispredict_cnt;

    logic [HIST_BITS-1:0] w_idx;
    logic [1:0]           w_entry;
    logic [1:0]           w_entry_next;
    logic                 w_pred;
    logic                 w_miss;
    logic                 w_unused_addr;

    // Upper PC bits do not participate in indexing
    assign w_unused_addr = ^branch_address[63:HIST_BITS];

    // Index with the pre-update history; read the pre-update counter
    assign w_idx   = branch_address[HIST_BITS-1:0] ^ r_ghr;
    assign w_entry = r_pht[w_idx];
    assign w_pred  = w_entry[1];
    assign w_miss  = w_pred ^ real_ton;

    // Saturating 2-bit counter update toward the resolved outcome
    always_comb begin
        w_entry_next = w_entry;
        if (real_ton && (w_entry != 2'b11)) begin
            w_entry_next = w_entry + 2'b01;
        end else if (!real_ton && (w_entry != 2'b00)) begin
            w_entry_next = w_entry - 2'b01;
        end
    end

    // Pattern history table: all entries weakly not-taken out of reset
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_pht <= '{default: 2'b01};
        end else if (branch_valid_i) begin
            r_pht[w_idx] <= w_entry_next;
        end
    end

    // Global history, per-branch result outputs and saturating statistics
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_ghr            <= '0;
            r_pred           <= 1'b0;
            r_pred_valid     <= 1'b0;
            r_mispredict     <= 1'b0;
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else if (branch_valid_i) begin
            r_ghr        <= {r_ghr[HIST_BITS-2:0], real_ton};
            r_pred       <= w_pred;
            r_pred_valid <= 1'b1;
            r_mispredict <= w_miss;
            if (r_branch_cnt != '1) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_miss && (r_mispredict_cnt != '1)) begin
                r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
            end
        end else begin
            r_pred_valid <= 1'b0;
            r_mispredict <= 1'b0;
        end
    end

    assign prediction_o       = r_pred;
    assign pred_valid_o       = r_pred_valid;
    assign mispredict_o       = r_mispredict;
    assign ghr_o              = r_ghr;
    assign branch_count_o     = r_branch_cnt;
    assign mispredict_count_o = r_mispredict_cnt;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: a default instance (HIST_BITS=8,
// CNT_W=32) and a CNT_W=4 instance share one stimulus stream.
`timescale 1ns/1ps
module tb_gshare_predictor;

    logic        clk;
    logic        clk_en;
    logic        reset_i;
    logic        branch_valid_i;
    logic [63:0] branch_address;
    logic        real_ton;

    logic        prediction_o,  pred_valid_o,  mispredict_o;
    logic [7:0]  ghr_o;
    logic [31:0] branch_count_o, mispredict_count_o;

    logic        prediction4,   pred_valid4,   mispredict4;
    logic [7:0]  ghr4;
    logic [3:0]  branch_count4,  mispredict_count4;

    int n_total;
    int n_bad;

    gshare_predictor #(.HIST_BITS(8), .CNT_W(32)) dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .branch_valid_i    (branch_valid_i),
        .branch_address    (branch_address),
        .real_ton          (real_ton),
        .prediction_o      (prediction_o),
        .pred_valid_o      (pred_valid_o),
        .mispredict_o      (mispredict_o),
        .ghr_o             (ghr_o),
        .branch_count_o    (branch_count_o),
        .mispredict_count_o(mispredict_count_o)
    );

    gshare_predictor #(.HIST_BITS(8), .CNT_W(4)) dut4 (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .branch_valid_i    (branch_valid_i),
        .branch_address    (branch_address),
        .real_ton          (real_ton),
        .prediction_o      (prediction4),
        .pred_valid_o      (pred_valid4),
        .mispredict_o      (mispredict4),
        .ghr_o             (ghr4),
        .branch_count_o    (branch_count4),
        .mispredict_count_o(mispredict_count4)
    );

    // Gated clock so reset can be exercised with no clock running
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, return 1ns after the rising edge
    task automatic step(input logic [63:0] addr, input logic ton, input logic vld);
        @(negedge clk);
        branch_address = addr;
        real_ton       = ton;
        branch_valid_i = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        branch_valid_i = 1'b0;
        reset_i = 1'b1;
        #1;
        reset_i = 1'b0;
    endtask

    task automatic chk_branch(input string tag, input logic p, input logic m,
                              input logic [7:0] g, input int bc, input int mc);
        chk({tag, ".pred"}, 64'(prediction_o), 64'(p));
        chk({tag, ".vld"},  64'(pred_valid_o), 64'd1);
        chk({tag, ".mis"},  64'(mispredict_o), 64'(m));
        chk({tag, ".ghr"},  64'(ghr_o), 64'(g));
        chk({tag, ".bcnt"}, 64'(branch_count_o), 64'(bc));
        chk({tag, ".mcnt"}, 64'(mispredict_count_o), 64'(mc));
    endtask

    initial begin
        logic [7:0] g;
        logic [7:0] idx;
        n_total        = 0;
        n_bad          = 0;
        clk_en         = 1'b0;
        reset_i        = 1'b0;
        branch_valid_i = 1'b0;
        branch_address = '0;
        real_ton       = 1'b0;

        // 1: async reset with the clock stopped
        #2 reset_i = 1'b1;
        #2;
        chk("rst.pred",  64'(prediction_o), 64'd0);
        chk("rst.vld",   64'(pred_valid_o), 64'd0);
        chk("rst.mis",   64'(mispredict_o), 64'd0);
        chk("rst.ghr",   64'(ghr_o), 64'd0);
        chk("rst.bcnt",  64'(branch_count_o), 64'd0);
        chk("rst.mcnt",  64'(mispredict_count_o), 64'd0);
        chk("rst4.bcnt", 64'(branch_count4), 64'd0);
        #2 reset_i = 1'b0;
        clk_en = 1'b1;

        // 2: first branch, idx 0x01 not taken; then re-hit idx 0x01 taken (entry 00)
        step(64'h0000_54A1_0000_0001, 1'b0, 1'b1);
        chk_branch("t2a", 1'b0, 1'b0, 8'h00, 1, 0);
        step(64'h0000_0000_0000_0001, 1'b1, 1'b1);
        chk_branch("t2b", 1'b0, 1'b1, 8'h01, 2, 1);

        // 3: 0xB taken x8 -> fresh indices, all mispredict
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            step(64'h0B, 1'b1, 1'b1);
            chk("t3.mis", 64'(mispredict_o), 64'd1);
        end
        chk("t3.ghr",  64'(ghr_o), 64'hFF);
        chk("t3.mcnt", 64'(mispredict_count_o), 64'd8);
        // idx 0xF4 back to back: 01->10 (pred 0), 10->11 (pred 1), 11 holds (pred 1)
        step(64'h0B, 1'b1, 1'b1);
        chk_branch("t3c", 1'b0, 1'b1, 8'hFF, 9, 9);
        step(64'h0B, 1'b1, 1'b1);
        chk_branch("t3d", 1'b1, 1'b0, 8'hFF, 10, 9);
        step(64'h0B, 1'b1, 1'b1);
        chk_branch("t3e", 1'b1, 1'b0, 8'hFF, 11, 9);
        step(64'h0B, 1'b1, 1'b1);
        chk_branch("t3f", 1'b1, 1'b0, 8'hFF, 12, 9);
        step(64'hFFFF_0000_0000_000B, 1'b0, 1'b1);
        chk_branch("t3g", 1'b1, 1'b1, 8'hFE, 13, 10);

        // 4: ten idle cycles -> state frozen, prediction holds
        for (int i = 0; i < 10; i++) begin
            step(64'(i * 37), 1'(i), 1'b0);
            chk("t4.vld", 64'(pred_valid_o), 64'd0);
            chk("t4.mis", 64'(mispredict_o), 64'd0);
        end
        chk("t4.pred", 64'(prediction_o), 64'd1);
        chk("t4.ghr",  64'(ghr_o), 64'hFE);
        chk("t4.bcnt", 64'(branch_count_o), 64'd13);
        chk("t4.mcnt", 64'(mispredict_count_o), 64'd10);

        // 5: reset pulse between edges while a stream is running
        step(64'h05, 1'b1, 1'b1);
        chk("t5.pre.bcnt", 64'(branch_count_o), 64'd14);
        #2 reset_i = 1'b1;
        #1;
        chk("t5.rst.pred", 64'(prediction_o), 64'd0);
        chk("t5.rst.vld",  64'(pred_valid_o), 64'd0);
        chk("t5.rst.ghr",  64'(ghr_o), 64'd0);
        chk("t5.rst.bcnt", 64'(branch_count_o), 64'd0);
        chk("t5.rst.mcnt", 64'(mispredict_count_o), 64'd0);
        reset_i = 1'b0;
        step(64'hCBA, 1'b0, 1'b1);
        chk_branch("t5b", 1'b0, 1'b0, 8'h00, 1, 0);

        // 6: 20 taken branches steered to fresh indices 0x20+i -> every one mispredicts
        pulse_reset();
        for (int i = 0; i < 20; i++) begin
            g   = (i >= 8) ? 8'hFF : 8'((1 << i) - 1);
            idx = 8'(8'h20 + i);
            step(64'hABCD_0000_0000_0000 | 64'(idx ^ g), 1'b1, 1'b1);
            chk("t6.mis", 64'(mispredict_o), 64'd1);
            if (i == 14) begin
                chk("t6.b4_15", 64'(branch_count4), 64'hF);
            end
        end
        chk("t6.b4",   64'(branch_count4), 64'hF);
        chk("t6.m4",   64'(mispredict_count4), 64'hF);
        chk("t6.bcnt", 64'(branch_count_o), 64'd20);
        chk("t6.mcnt", 64'(mispredict_count_o), 64'd20);
        chk("t6.ghr",  64'(ghr_o), 64'hFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
